// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types, constants and helpers for the pipeline hazard scheduler.
//   - TUSE_NONE     : Tuse value meaning "operand not read"
//   - fwd_sel_e     : D-stage forward select encoding (GRF/E/M/W)
//   - stage_t       : tracked {WE, Addr, Tnew} entry of one pipeline stage
//   - sat_dec()     : saturating Tnew decrement applied on each stage advance
//   - stage_match() : stage writes a nonzero register equal to r
package hazard_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int TNEW_W = 2;
  localparam int TUSE_W = 2;

  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [TNEW_W-1:0] tnew;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic stage_match(input stage_t s, input logic [ADDR_W-1:0] r);
    return s.we && (s.addr == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage_reg.sv
// hazard_stage_reg
//   One tracked pipeline-stage entry {WE, Addr, Tnew}.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears to bubble)
//     bubble     : load a bubble instead of din on this edge
//     din        : entry coming from the previous stage
//     q          : registered entry
//   Parameter DEC selects whether Tnew is saturating-decremented on load
//   (M and W stages) or passed through unchanged (E stage, fed from D).
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble,
  input  stage_t din,
  output stage_t q
);

  stage_t nxt;

  // NOTE: every always_comb output gets a full default first so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    nxt = din;
    if (DEC) nxt.tnew = sat_dec(din.tnew);
    if (bubble) nxt = BUBBLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= BUBBLE;
    else        q <= nxt;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard scheduler for the 5-stage MIPS core. Tracks {WE, Addr, Tnew} of
//   the instructions in E, M and W, compares them against the Tuse of the
//   D-stage operands, and raises Stall (freeze PC and F/D, bubble into E).
//   Also provides the tracked M/W state to the E-stage forward mux and the
//   D-stage forward selects for the branch comparator.
//   Optional feature macro: HAZARD_MDU_EN (multiply/divide busy counter and
//   MDU structural stall). Without it the MDU inputs are ignored and
//   MDU_Busy is tied low.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     D_Rs, D_Rt                 D-stage source registers
//     D_TuseRs, D_TuseRt         cycles until operand is needed (3 = unused)
//     D_GRFWE, D_Addr, D_Tnew    D-stage destination tracking info
//     D_MDUOp                    D instruction uses the MDU
//     E_MDUStart, E_MDUDiv       E starts mult (0) / div (1) this cycle
//     Flush                      kill the D->E transfer this edge
//     Stall                      freeze PC and F/D, bubble into E
//     E_/M_/W_{GRFWE,Addr,Tnew}  tracked stage state
//     D_FwdRs, D_FwdRt           0 GRF, 1 E, 2 M, 3 W
//     MDU_Busy                   busy counter nonzero
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] D_Rs,
  input  logic [ADDR_W-1:0] D_Rt,
  input  logic [TUSE_W-1:0] D_TuseRs,
  input  logic [TUSE_W-1:0] D_TuseRt,
  input  logic              D_GRFWE,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              D_MDUOp,
  input  logic              E_MDUStart,
  input  logic              E_MDUDiv,
  input  logic              Flush,
  output logic              Stall,
  output logic              E_GRFWE,
  output logic [ADDR_W-1:0] E_Addr,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic              M_GRFWE,
  output logic [ADDR_W-1:0] M_Addr,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic              W_GRFWE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [TNEW_W-1:0] W_Tnew,
  output logic [1:0]        D_FwdRs,
  output logic [1:0]        D_FwdRt,
  output logic              MDU_Busy
);

  stage_t e_q, m_q, w_q;
  logic   grf_stall, mdu_stall;

  // E is loaded straight from D (Tnew counted from E entry); M and W age it.
  hazard_stage_reg #(.DEC(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .bubble(Stall | Flush),
    .din('{we: D_GRFWE, addr: D_Addr, tnew: D_Tnew}), .q(e_q)
  );
  hazard_stage_reg #(.DEC(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0), .din(e_q), .q(m_q)
  );
  hazard_stage_reg #(.DEC(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0), .din(m_q), .q(w_q)
  );

  // A producer stalls the consumer only if its result arrives later than
  // the consumer needs it. W always has Tnew==0, so it is never checked.
  function automatic logic operand_hazard(input logic [ADDR_W-1:0] r,
                                          input logic [TUSE_W-1:0] tuse);
    if (tuse == TUSE_NONE) return 1'b0;
    return (stage_match(e_q, r) && (e_q.tnew > tuse)) ||
           (stage_match(m_q, r) && (m_q.tnew > tuse));
  endfunction

  // Youngest ready producer wins; a matching producer that is not ready yet
  // blocks nothing here because Stall covers that case.
  function automatic fwd_sel_e fwd_select(input logic [ADDR_W-1:0] r);
    if (stage_match(e_q, r) && (e_q.tnew == '0)) return FWD_E;
    if (stage_match(m_q, r) && (m_q.tnew == '0)) return FWD_M;
    if (stage_match(w_q, r) && (w_q.tnew == '0)) return FWD_W;
    return FWD_GRF;
  endfunction

  assign grf_stall = operand_hazard(D_Rs, D_TuseRs) | operand_hazard(D_Rt, D_TuseRt);
  assign Stall     = grf_stall | mdu_stall;
  assign D_FwdRs   = fwd_select(D_Rs);
  assign D_FwdRt   = fwd_select(D_Rt);

`ifdef HAZARD_MDU_EN
  logic [CNT_W-1:0] busy_cnt;

  // NOTE: the busy counter is a handful of control flops, so it is reset
  // like all other state; only wide storage arrays are left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (E_MDUStart && (busy_cnt == '0)) begin
      busy_cnt <= E_MDUDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // The start cycle itself is busy too, even though the counter is still 0.
  assign mdu_stall = D_MDUOp & (E_MDUStart | (busy_cnt != '0));
  assign MDU_Busy  = (busy_cnt != '0);
`else
  logic unused_mdu;
  assign unused_mdu = ^{D_MDUOp, E_MDUStart, E_MDUDiv,
                        CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
  assign mdu_stall  = 1'b0;
  assign MDU_Busy   = 1'b0;
`endif

  assign E_GRFWE = e_q.we;
  assign E_Addr  = e_q.addr;
  assign E_Tnew  = e_q.tnew;
  assign M_GRFWE = m_q.we;
  assign M_Addr  = m_q.addr;
  assign M_Tnew  = m_q.tnew;
  assign W_GRFWE = w_q.we;
  assign W_Addr  = w_q.addr;
  assign W_Tnew  = w_q.tnew;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl. Expected values are
//   hand-derived pipeline occupancy. Exercises the MDU path when compiled
//   with HAZARD_MDU_EN, otherwise checks that MDU inputs have no effect.
module tb_hazard_ctrl;

  localparam int DIV_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_Rs, D_Rt, D_Addr;
  logic [1:0] D_TuseRs, D_TuseRt, D_Tnew;
  logic       D_GRFWE, D_MDUOp, E_MDUStart, E_MDUDiv, Flush;
  logic       Stall, MDU_Busy;
  logic       E_GRFWE, M_GRFWE, W_GRFWE;
  logic [4:0] E_Addr, M_Addr, W_Addr;
  logic [1:0] E_Tnew, M_Tnew, W_Tnew, D_FwdRs, D_FwdRt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
    .D_GRFWE(D_GRFWE), .D_Addr(D_Addr), .D_Tnew(D_Tnew),
    .D_MDUOp(D_MDUOp), .E_MDUStart(E_MDUStart), .E_MDUDiv(E_MDUDiv),
    .Flush(Flush), .Stall(Stall),
    .E_GRFWE(E_GRFWE), .E_Addr(E_Addr), .E_Tnew(E_Tnew),
    .M_GRFWE(M_GRFWE), .M_Addr(M_Addr), .M_Tnew(M_Tnew),
    .W_GRFWE(W_GRFWE), .W_Addr(W_Addr), .W_Tnew(W_Tnew),
    .D_FwdRs(D_FwdRs), .D_FwdRt(D_FwdRt), .MDU_Busy(MDU_Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_idle();
    D_Rs = 5'd0; D_Rt = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3;
    D_GRFWE = 1'b0; D_Addr = 5'd0; D_Tnew = 2'd0;
    D_MDUOp = 1'b0; E_MDUStart = 1'b0; E_MDUDiv = 1'b0; Flush = 1'b0;
  endtask

  int stall_cnt, busy_cnt;

  initial begin
    // ---------------- reset with random D-stage inputs
    rst_n = 1'b0;
    d_idle();
    D_Rs = 5'($urandom); D_Rt = 5'($urandom);
    D_TuseRs = 2'($urandom); D_TuseRt = 2'($urandom);
    D_GRFWE = 1'b1; D_Addr = 5'($urandom); D_Tnew = 2'($urandom);
    Flush = 1'($urandom);
    #3;
    check("rst_stall", Stall, 0);
    check("rst_fwd", {D_FwdRs, D_FwdRt}, 0);
    check("rst_busy", MDU_Busy, 0);
    tick(); tick();
    check("rst_stage", {E_GRFWE, E_Addr, E_Tnew, M_GRFWE, M_Addr, M_Tnew}, 0);
    check("rst_w", {W_GRFWE, W_Addr, W_Tnew}, 0);
    d_idle();
    rst_n = 1'b1;
    #1;
    check("rel_stall", Stall, 0);

    // ---------------- lw $2 then beq rs=$2 Tuse=0
    tick();
    D_GRFWE = 1'b1; D_Addr = 5'd2; D_Tnew = 2'd2;
    tick();                                   // lw now in E
    d_idle(); D_Rs = 5'd2; D_TuseRs = 2'd0; D_TuseRt = 2'd0;
    #1;
    check("lw_e_stall", Stall, 1);
    check("lw_e_tnew", E_Tnew, 2);
    tick();                                   // lw in M, bubble in E
    check("lw_m_stall", Stall, 1);
    check("lw_bubble1", E_GRFWE, 0);
    check("lw_m_state", {M_GRFWE, M_Addr, M_Tnew}, {1'b1, 5'd2, 2'd1});
    tick();                                   // lw in W, second bubble
    check("lw_w_stall", Stall, 0);
    check("lw_fwd_w", D_FwdRs, 3);
    check("lw_bubble2", {E_GRFWE, M_GRFWE}, 0);
    check("lw_w_state", {W_GRFWE, W_Addr, W_Tnew}, {1'b1, 5'd2, 2'd0});

    // ---------------- addu $3 (Tnew=1) then addu rs=$3 Tuse=1
    d_idle(); D_GRFWE = 1'b1; D_Addr = 5'd3; D_Tnew = 2'd1;
    tick();                                   // addu $3 in E
    d_idle(); D_Rs = 5'd3; D_TuseRs = 2'd1;
    D_GRFWE = 1'b1; D_Addr = 5'd4; D_Tnew = 2'd1;
    #1;
    check("alu_nostall", Stall, 0);
    check("alu_fwd_none", D_FwdRs, 0);
    tick();                                   // $3 in M, $4 in E
    check("alu_m_state", {M_GRFWE, M_Addr, M_Tnew}, {1'b1, 5'd3, 2'd0});
    check("alu_e_state", {E_GRFWE, E_Addr, E_Tnew}, {1'b1, 5'd4, 2'd1});
    d_idle(); D_Rs = 5'd3; D_TuseRs = 2'd0;
    #1;
    check("alu_fwd_m", D_FwdRs, 2);
    check("alu_m_nostall", Stall, 0);

    // ---------------- write to $0 is never a dependency
    d_idle(); tick(); tick(); tick();
    D_GRFWE = 1'b1; D_Addr = 5'd0; D_Tnew = 2'd2;
    tick();                                   // $0 writer in E, Tnew=2
    d_idle(); D_Rs = 5'd0; D_TuseRs = 2'd0;
    D_GRFWE = 1'b1; D_Addr = 5'd5; D_Tnew = 2'd0;
    #1;
    check("zero_stall", Stall, 0);
    check("zero_fwd", D_FwdRs, 0);
    tick();                                   // $5 in E with Tnew=0
    d_idle(); D_Rt = 5'd5; D_TuseRt = 2'd0;
    #1;
    check("fwd_e_rt", D_FwdRt, 1);
    check("fwd_e_nostall", Stall, 0);

    // ---------------- MDU structural hazard
    d_idle(); tick(); tick(); tick();
    D_MDUOp = 1'b1; E_MDUStart = 1'b1; E_MDUDiv = 1'b1;
    #1;
    stall_cnt = 0;
    busy_cnt  = 0;
    for (int i = 0; i < 2 * DIV_CYCLES; i++) begin
      if (Stall) stall_cnt++;
      if (MDU_Busy) busy_cnt++;
      tick();
      E_MDUStart = 1'b0;
      #1;
    end
`ifdef HAZARD_MDU_EN
    check("mdu_stall_cycles", 8'(stall_cnt), 8'(DIV_CYCLES + 1));
    check("mdu_busy_cycles", 8'(busy_cnt), 8'(DIV_CYCLES));
`else
    check("mdu_stall_cycles", 8'(stall_cnt), 0);
    check("mdu_busy_cycles", 8'(busy_cnt), 0);
`endif
    check("mdu_idle_end", {Stall, MDU_Busy}, 0);

    // ---------------- Flush during Stall, then reset mid-stall
    d_idle(); tick();
    D_GRFWE = 1'b1; D_Addr = 5'd6; D_Tnew = 2'd2;
    tick();                                   // lw $6 in E
    d_idle(); D_Rs = 5'd6; D_TuseRs = 2'd0;
    D_GRFWE = 1'b1; D_Addr = 5'd7; D_Tnew = 2'd1; Flush = 1'b1;
    #1;
    check("flush_stall", Stall, 1);
    tick();
    Flush = 1'b0;
    #1;
    check("flush_bubble", {E_GRFWE, E_Addr, E_Tnew}, 0);
    check("flush_m", {M_GRFWE, M_Addr, M_Tnew}, {1'b1, 5'd6, 2'd1});
    check("flush_still_stall", Stall, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", Stall, 0);
    check("midrst_state", {E_GRFWE, M_GRFWE, M_Addr, M_Tnew, W_GRFWE}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", Stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
